// File: rtl/p_pkg.sv
// Shared definitions for the Poly1305 MAC-input formatter: FSM states, block geometry,
// tail-byte mask and length-block construction.
package p_pkg;

  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = 8 * BLK_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_HOLD,
    ST_SEND,
    ST_DONE
  } state_e;

  // Byte k of the mask is 0xFF when k < n_bytes; n_bytes = 16 keeps the whole block.
  function automatic logic [BLK_W-1:0] byte_mask(input logic [4:0] n_bytes);
    logic [BLK_W-1:0] m;
    m = '0;
    for (int k = 0; k < BLK_BYTES; k++) begin
      if (5'(k) < n_bytes) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [BLK_W-1:0] len_block(input logic [63:0] aad_bytes,
                                                 input logic [63:0] ct_bytes);
    return {ct_bytes, aad_bytes};
  endfunction

endpackage

// File: rtl/p_blk_mask.sv
// Combinational tail masking: keeps the first min(rem_i, 16) bytes of a raw block.
module p_blk_mask import p_pkg::*; #(
  parameter int LEN_W = 32
) (
  input  logic [BLK_W-1:0] data_i,
  input  logic [LEN_W-1:0] rem_i,
  output logic [BLK_W-1:0] data_o
);

  logic [4:0] n_bytes;

  assign n_bytes = (rem_i >= LEN_W'(BLK_BYTES)) ? 5'(BLK_BYTES) : rem_i[4:0];
  assign data_o  = data_i & byte_mask(n_bytes);

endmodule

// File: rtl/p_mac_fmt.sv
// Builds the RFC 8439 Poly1305 input stream (padded AAD, padded CT, length block) and
// hands it one 128-bit block at a time to the tag stage, prefetching one block ahead.
module p_mac_fmt import p_pkg::*; #(
  parameter int LEN_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len_aad,
  input  logic [LEN_W-1:0] i_len_ct,
  output logic             o_rd_req,
  output logic             o_rd_sel,
  input  logic             i_rd_valid,
  input  logic [127:0]     i_rd_data,
  output logic             o_start,
  output logic [LEN_W-1:0] o_len_msg,
  input  logic             i_sig_req,
  output logic             o_sig_msg,
  output logic [127:0]     o_msg,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] BLK_L = LEN_W'(BLK_BYTES);
  localparam logic [LEN_W-1:0] PAD_L = LEN_W'(BLK_BYTES - 1);

  state_e           state_q;
  logic [LEN_W-1:0] len_aad_q, len_ct_q, len_msg_q;
  logic [LEN_W-1:0] aad_rem_q, ct_rem_q;
  logic             len_sent_q, first_q, rd_busy_q, rd_sel_q, pend_q;
  logic             rd_req_q, start_q, sig_msg_q, busy_q, done_q;
  logic [BLK_W-1:0] buf_q, msg_q;

  logic [LEN_W-1:0] len_msg_d, nxt_aad, nxt_ct, rd_rem, aad_rem_d, ct_rem_d;
  logic [BLK_W-1:0] masked, blk_d;
  logic             fetch_data, fetch_sel, fetch_done, more_blk;

  assign len_msg_d = ((i_len_aad + PAD_L) & ~PAD_L) + ((i_len_ct + PAD_L) & ~PAD_L) + BLK_L;

  assign rd_rem = rd_sel_q ? ct_rem_q : aad_rem_q;

  p_blk_mask #(.LEN_W(LEN_W)) u_blk_mask (
    .data_i (i_rd_data),
    .rem_i  (rd_rem),
    .data_o (masked)
  );

  // With no read outstanding in FETCH, both sections are exhausted: build the length block.
  assign blk_d      = rd_busy_q ? masked : len_block(64'(len_aad_q), 64'(len_ct_q));
  assign fetch_done = rd_busy_q ? i_rd_valid : 1'b1;

  assign aad_rem_d = (aad_rem_q > BLK_L) ? aad_rem_q - BLK_L : '0;
  assign ct_rem_d  = (ct_rem_q  > BLK_L) ? ct_rem_q  - BLK_L : '0;
  assign more_blk  = (aad_rem_q != '0) || (ct_rem_q != '0) || !len_sent_q;

  // The first fetch is decided from the lengths being latched, later ones from the remainders.
  assign nxt_aad = (state_q == ST_IDLE) ? i_len_aad : aad_rem_q;
  assign nxt_ct  = (state_q == ST_IDLE) ? i_len_ct  : ct_rem_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    fetch_data = 1'b0;
    fetch_sel  = 1'b0;
    if (nxt_aad != '0) begin
      fetch_data = 1'b1;
    end else if (nxt_ct != '0) begin
      fetch_data = 1'b1;
      fetch_sel  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: buf_q/msg_q are plain flops, not a RAM, so they take the async clear too.
      state_q    <= ST_IDLE;
      len_aad_q  <= '0;
      len_ct_q   <= '0;
      len_msg_q  <= '0;
      aad_rem_q  <= '0;
      ct_rem_q   <= '0;
      len_sent_q <= 1'b0;
      first_q    <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      pend_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      sig_msg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_q      <= '0;
      msg_q      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
      rd_req_q  <= 1'b0;
      start_q   <= 1'b0;
      sig_msg_q <= 1'b0;
      done_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            len_aad_q  <= i_len_aad;
            len_ct_q   <= i_len_ct;
            len_msg_q  <= len_msg_d;
            aad_rem_q  <= i_len_aad;
            ct_rem_q   <= i_len_ct;
            len_sent_q <= 1'b0;
            first_q    <= 1'b1;
            pend_q     <= 1'b0;
            busy_q     <= 1'b1;
            rd_req_q   <= fetch_data;
            rd_busy_q  <= fetch_data;
            rd_sel_q   <= fetch_sel;
            state_q    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (i_sig_req) pend_q <= 1'b1;
          if (fetch_done) begin
            buf_q <= blk_d;
            if (rd_busy_q) begin
              rd_busy_q <= 1'b0;
              if (rd_sel_q) ct_rem_q  <= ct_rem_d;
              else          aad_rem_q <= aad_rem_d;
            end else begin
              len_sent_q <= 1'b1;
            end
            if (first_q) begin
              first_q <= 1'b0;
              start_q <= 1'b1;
              msg_q   <= blk_d;
              state_q <= ST_START;
            end else if (pend_q || i_sig_req) begin
              pend_q    <= 1'b0;
              sig_msg_q <= 1'b1;
              msg_q     <= blk_d;
              state_q   <= ST_SEND;
            end else begin
              state_q <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (i_sig_req) begin
            sig_msg_q <= 1'b1;
            msg_q     <= buf_q;
            state_q   <= ST_SEND;
          end
        end

        ST_START, ST_SEND: begin
          if (state_q == ST_START && i_sig_req && more_blk) pend_q <= 1'b1;
          if (more_blk) begin
            rd_req_q  <= fetch_data;
            rd_busy_q <= fetch_data;
            rd_sel_q  <= fetch_sel;
            state_q   <= ST_FETCH;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_req  = rd_req_q;
  assign o_rd_sel  = rd_sel_q;
  assign o_start   = start_q;
  assign o_len_msg = len_msg_q;
  assign o_sig_msg = sig_msg_q;
  assign o_msg     = msg_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_p_mac_fmt.sv
// Self-checking bench for p_mac_fmt: a byte-stream reference model of the RFC 8439 MAC
// input, a randomized-latency source and a randomized-timing tag stage.
module tb_p_mac_fmt;

  localparam int LEN_W = 32;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_start;
  logic [LEN_W-1:0] i_len_aad;
  logic [LEN_W-1:0] i_len_ct;
  logic             o_rd_req;
  logic             o_rd_sel;
  logic             i_rd_valid;
  logic [127:0]     i_rd_data;
  logic             o_start;
  logic [LEN_W-1:0] o_len_msg;
  logic             i_sig_req;
  logic             o_sig_msg;
  logic [127:0]     o_msg;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  p_mac_fmt #(.LEN_W(LEN_W)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (i_start),
    .i_len_aad  (i_len_aad),
    .i_len_ct   (i_len_ct),
    .o_rd_req   (o_rd_req),
    .o_rd_sel   (o_rd_sel),
    .i_rd_valid (i_rd_valid),
    .i_rd_data  (i_rd_data),
    .o_start    (o_start),
    .o_len_msg  (o_len_msg),
    .i_sig_req  (i_sig_req),
    .o_sig_msg  (o_sig_msg),
    .o_msg      (o_msg),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete message: the tag stream expected is the RFC 8439 byte layout cut into
  // 16-byte blocks; timing expectations follow the prefetch / one-cycle-response rules.
  task automatic run_msg(input int aad, input int ct, input bit fill_ff,
                         input int lat_min, input int lat_max,
                         input int dly_min, input int dly_max,
                         input bit spur, input bit dbl_start, input bit abort_ct);
    logic [127:0]     aad_raw[$];
    logic [127:0]     ct_raw[$];
    logic [127:0]     exp_blk[$];
    logic [7:0]       bq[$];
    logic [127:0]     w;
    logic [63:0]      lw;
    logic [LEN_W-1:0] exp_len;
    int n_aad, n_ct, total, c, prev_evt, valid_c, req_c, done_c, ready, nb;
    int n_rd_aad, n_rd_ct, n_srv_aad, n_srv_ct, cd, tag_cd;
    bit outstanding, out_sel, aborted;

    n_aad = (aad + 15) / 16;
    n_ct  = (ct + 15) / 16;
    for (int i = 0; i < n_aad; i++) aad_raw.push_back(fill_ff ? {128{1'b1}} : rand128());
    for (int i = 0; i < n_ct; i++)  ct_raw.push_back(fill_ff ? {128{1'b1}} : rand128());

    for (int i = 0; i < aad; i++) begin
      w = aad_raw[i / 16];
      bq.push_back(w[8*(i % 16) +: 8]);
    end
    while (bq.size() % 16 != 0) bq.push_back(8'h00);
    for (int i = 0; i < ct; i++) begin
      w = ct_raw[i / 16];
      bq.push_back(w[8*(i % 16) +: 8]);
    end
    while (bq.size() % 16 != 0) bq.push_back(8'h00);
    lw = 64'(aad);
    for (int i = 0; i < 8; i++) bq.push_back(lw[8*i +: 8]);
    lw = 64'(ct);
    for (int i = 0; i < 8; i++) bq.push_back(lw[8*i +: 8]);
    for (int j = 0; j < bq.size() / 16; j++) begin
      w = '0;
      for (int k = 0; k < 16; k++) w[8*k +: 8] = bq[16*j + k];
      exp_blk.push_back(w);
    end
    total   = bq.size() / 16;
    exp_len = LEN_W'(bq.size());

    c = 0; prev_evt = 0; valid_c = 0; req_c = -1; done_c = -1; nb = 0;
    n_rd_aad = 0; n_rd_ct = 0; n_srv_aad = 0; n_srv_ct = 0; cd = 0; tag_cd = 0;
    outstanding = 1'b0; out_sel = 1'b0; aborted = 1'b0;

    @(negedge i_clk);
    i_len_aad = LEN_W'(aad);
    i_len_ct  = LEN_W'(ct);
    i_start   = 1'b1;

    while (!aborted && !(done_c >= 0 && c > done_c) && c < 2000) begin
      @(negedge i_clk);
      c++;
      i_start    = 1'b0;
      i_rd_valid = 1'b0;
      i_sig_req  = 1'b0;
      i_rd_data  = rand128();

      if (o_rd_req) begin
        check("rd_req_lat", 128'(c), 128'(prev_evt + 1));
        check("rd_sel", 128'(o_rd_sel), 128'((n_rd_aad < n_aad) ? 0 : 1));
        if (o_rd_sel) n_rd_ct++;
        else          n_rd_aad++;
        outstanding = 1'b1;
        out_sel     = o_rd_sel;
        cd          = int'($urandom_range(lat_max, lat_min)) + 1;
      end

      if (o_start || o_sig_msg) begin
        ready = (nb == total - 1) ? prev_evt + 1 : valid_c;
        if (o_start) begin
          check("start_idx", 128'(nb), 128'(0));
          check("len_msg", 128'(o_len_msg), 128'(exp_len));
          check("start_lat", 128'(c), 128'(ready + 1));
        end else begin
          check("sig_solicited", 128'(req_c >= 0), 128'(1));
          check("sig_lat", 128'(c), 128'(((req_c > ready) ? req_c : ready) + 1));
        end
        check("blk_in_range", 128'(nb < total), 128'(1));
        if (nb < total) check($sformatf("blk%0d", nb), o_msg, exp_blk[nb]);
        prev_evt = c;
        req_c    = -1;
        nb++;
        if (nb < total) tag_cd = int'($urandom_range(dly_max, dly_min)) + 1;
      end

      if (o_done) begin
        check("done_lat", 128'(c), 128'(prev_evt + 1));
        check("done_cnt", 128'(nb), 128'(total));
        done_c = c;
      end

      if (abort_ct && outstanding && n_rd_ct >= 2) begin
        #2 i_rstn = 1'b0;
        #1;
        check("rst_ctl", 128'({o_rd_req, o_rd_sel, o_start, o_sig_msg, o_busy, o_done}), 128'(0));
        check("rst_msg", o_msg, 128'(0));
        check("rst_len", 128'(o_len_msg), 128'(0));
        @(negedge i_clk);
        i_rstn     = 1'b1;
        i_rd_valid = 1'b1;
        i_sig_req  = 1'b1;
        i_rd_data  = rand128();
        for (int k = 0; k < 4; k++) begin
          @(negedge i_clk);
          i_rd_valid = 1'b0;
          i_sig_req  = 1'b0;
          check("post_rst_idle", 128'({o_rd_req, o_start, o_sig_msg, o_busy, o_done}), 128'(0));
        end
        aborted = 1'b1;
      end else begin
        if (outstanding) begin
          cd--;
          if (cd == 0) begin
            check("rd_sel_hold", 128'(o_rd_sel), 128'(out_sel));
            i_rd_valid = 1'b1;
            if (out_sel) begin
              if (n_srv_ct < ct_raw.size()) i_rd_data = ct_raw[n_srv_ct];
              n_srv_ct++;
            end else begin
              if (n_srv_aad < aad_raw.size()) i_rd_data = aad_raw[n_srv_aad];
              n_srv_aad++;
            end
            outstanding = 1'b0;
            valid_c     = c;
          end
        end else if (spur && !o_rd_req && $urandom_range(3, 0) == 0) begin
          i_rd_valid = 1'b1;
        end

        if (tag_cd > 0) begin
          tag_cd--;
          if (tag_cd == 0) begin
            i_sig_req = 1'b1;
            req_c     = c;
          end
        end

        if (dbl_start && c == 3) begin
          check("busy_mid", 128'(o_busy), 128'(1));
          i_start   = 1'b1;
          i_len_aad = LEN_W'($urandom_range(200, 1));
          i_len_ct  = LEN_W'($urandom_range(200, 1));
        end
      end
    end

    if (!aborted) begin
      check("run_finished", 128'(done_c >= 0), 128'(1));
      check("rd_aad_cnt", 128'(n_rd_aad), 128'(n_aad));
      check("rd_ct_cnt", 128'(n_rd_ct), 128'(n_ct));
      check("blk_cnt", 128'(nb), 128'(total));
      check("busy_idle", 128'(o_busy), 128'(0));
      check("len_stable", 128'(o_len_msg), 128'(exp_len));
      check("msg_hold", o_msg, exp_blk[total - 1]);
      if (spur) begin
        i_sig_req  = 1'b1;
        i_rd_valid = 1'b1;
        @(negedge i_clk);
        i_sig_req  = 1'b0;
        i_rd_valid = 1'b0;
        check("spur_idle", 128'({o_rd_req, o_start, o_sig_msg, o_busy, o_done}), 128'(0));
      end
    end
  endtask

  initial begin
    i_rstn     = 1'b0;
    i_start    = 1'b0;
    i_len_aad  = '0;
    i_len_ct   = '0;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    i_sig_req  = 1'b0;

    #12;
    check("reset_ctl", 128'({o_rd_req, o_rd_sel, o_start, o_sig_msg, o_busy, o_done}), 128'(0));
    check("reset_msg", o_msg, 128'(0));
    check("reset_len", 128'(o_len_msg), 128'(0));
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Empty message: only the all-zero length block.
    run_msg(0, 0, 1'b0, 1, 3, 1, 3, 1'b0, 1'b0, 1'b0);
    // Partial AAD and partial CT with all-ones source data.
    run_msg(12, 114, 1'b1, 1, 4, 1, 4, 1'b0, 1'b0, 1'b0);
    // Exactly one full AAD block, no CT.
    run_msg(16, 0, 1'b0, 1, 3, 1, 3, 1'b0, 1'b0, 1'b0);
    // Requests land during FETCH while the source takes 5 cycles.
    run_msg(40, 40, 1'b0, 5, 5, 1, 1, 1'b0, 1'b0, 1'b0);
    // A second i_start while busy must be ignored.
    run_msg(30, 50, 1'b0, 1, 3, 1, 4, 1'b0, 1'b1, 1'b0);
    // Asynchronous reset mid-CT, then a fresh message.
    run_msg(20, 100, 1'b0, 2, 4, 1, 3, 1'b0, 1'b0, 1'b1);
    run_msg(33, 47, 1'b0, 1, 3, 1, 3, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_msg(int'($urandom_range(60, 0)), int'($urandom_range(180, 0)), 1'b0,
              1, 4, 1, 5, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
